qdec_ctx_mem_arb: RTL

Arbiter and sequencer for the single-port CABAC context memory (1024 x 8b, entry = {ctxState[6:0], mps}).
It shares the memory between NUM_REQ requesters: requester 0 is context init, 1 is SAO, 2 is CQT.
It issues one memory operation per cycle and returns read data to the issuing requester in order.
It sits between the CABAC sub-FSMs and the context RAM, replacing per-state address muxing in the CABAC top.

---
 rtl/qdec_ctx_mem_arb_pkg.sv | 16 +
 rtl/qdec_ctx_mem_arb_rr.sv | 41 ++++
 rtl/qdec_ctx_mem_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/qdec_ctx_mem_arb_pkg.sv
// Shared types and constants for the CABAC context-memory arbiter.
// Context entry layout: {state[6:0], mps}.
package qdec_ctx_mem_arb_pkg;
  localparam int CTX_ADDR_W = 10;
  localparam int CTX_DATA_W = 8;

  typedef struct packed {
    logic [6:0] state;
    logic       mps;
  } t_ctx_entry;

  // Width of an index into n items, never less than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/qdec_ctx_mem_arb_rr.sv
// Round-robin grant among N requesters. The pointer names the requester
// holding top priority and moves past the winner only when adv is set.
module qdec_rr_arb
  import qdec_ctx_mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);
  localparam int PW = id_w(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  int            idx;

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt = '0;
    win = ptr;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (adv)
      ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
  end
endmodule

// File: rtl/qdec_ctx_mem_arb.sv
// Single-port context memory arbiter: fixed priority for context init,
// round-robin for the rest, one registered op per cycle, in-order read returns.
module qdec_ctx_mem_arb
  import qdec_ctx_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = CTX_ADDR_W,
  parameter int DATA_W  = CTX_DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lock0,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);
  localparam int IW  = id_w(NUM_REQ);
  localparam int NRR = NUM_REQ - 1;

  logic [NRR-1:0]     rr_gnt;
  logic               rr_adv;
  logic [NUM_REQ-1:0] gnt;
  logic               acc;
  logic               acc_we;
  logic [IW-1:0]      acc_id;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [RD_LAT:0]    trk_vld;
  logic [IW-1:0]      trk_id [RD_LAT+1];

  qdec_rr_arb #(.N(NRR)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vld[NUM_REQ-1:1]),
    .adv   (rr_adv),
    .gnt   (rr_gnt)
  );

  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (req_vld[0])
        gnt[0] = 1'b1;
      else if (!lock0)
        gnt[NUM_REQ-1:1] = rr_gnt;
    end
  end

  // Requester 0 grants and lock0 leave the round-robin pointer untouched.
  assign rr_adv  = rst_n && !req_vld[0] && !lock0 && (|rr_gnt);
  assign req_rdy = gnt;

  always_comb begin
    acc       = |gnt;
    acc_we    = 1'b0;
    acc_id    = '0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        acc_we    = req_we[i];
        acc_id    = IW'(i);
        acc_addr  = req_addr[i*ADDR_W +: ADDR_W];
        acc_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue stage: accepted command drives the memory one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= acc & acc_we;
      mem_re <= acc & ~acc_we;
      if (acc) begin
        mem_addr  <= acc_addr;
        mem_wdata <= acc_wdata;
      end
    end
  end

  // Read tracking: entry k lines up with the memory k cycles after issue.
  always_ff @(posedge clk) begin
    if (!rst_n)
      trk_vld <= '0;
    else
      trk_vld <= {trk_vld[RD_LAT-1:0], acc & ~acc_we};
  end

  always_ff @(posedge clk) begin
    trk_id[0] <= acc_id;
    for (int k = 1; k <= RD_LAT; k++)
      trk_id[k] <= trk_id[k-1];
  end

  // Response stage: capture read data as it becomes valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
    end else begin
      rsp_vld <= '0;
      if (trk_vld[RD_LAT]) begin
        rsp_vld[trk_id[RD_LAT]] <= 1'b1;
        rsp_data                <= mem_rdata;
      end
    end
  end

  assign busy = mem_we | (|trk_vld) | (|rsp_vld);
endmodule
